// File: rtl/sne_apb_resp_pkg.sv
// Shared types for the SNE APB config responder: FSM states, wait-counter width, error causes.
package sne_apb_resp_pkg;

    localparam int unsigned WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb_resp_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RO    = 2'd3
    } apb_err_cause_e;

endpackage

// File: rtl/sne_apb_regbank.sv
// Register storage with read-only status slots and self-clearing pulse slots.
// Write lands on the edge after wr_vld, strobe and cfg update are visible the next cycle; no backpressure.
module sne_apb_regbank
    import sne_apb_resp_pkg::*;
#(
    parameter int unsigned            NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]    PULSE_MASK = '0,
    localparam int unsigned           IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_vld,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [31:0]               wr_dat,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [31:0]               rd_dat,
    input  logic [NUM_REGS*32-1:0]    status_i,
    output logic [NUM_REGS*32-1:0]    cfg_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // A new write wins over the self-clear, so back-to-back pulses re-arm.
                if (wr_vld && (wr_idx == IDX_W'(i))) begin
                    regs_q[i] <= wr_dat;
                end else if (PULSE_MASK[i]) begin
                    regs_q[i] <= '0;
                end
                wr_pulse_o[i] <= wr_vld && (wr_idx == IDX_W'(i));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_o[i*32 +: 32] = RO_MASK[i] ? 32'd0 : regs_q[i];
        end
    end

    assign rd_dat = RO_MASK[rd_idx] ? status_i[32*rd_idx +: 32] : regs_q[rd_idx];

endmodule

// File: rtl/sne_apb_cfg_responder.sv
// APB3 completer for the SNE config register bank with programmable wait states and error response.
// pready WAIT_CYCLES+1 cycles after the first enable cycle; master stalls on pready, held enables never recommit.
module sne_apb_cfg_responder
    import sne_apb_resp_pkg::*;
#(
    parameter int unsigned            NUM_REGS    = 16,
    parameter logic [31:0]            BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned            WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]    PULSE_MASK  = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [NUM_REGS*32-1:0]    cfg_o,
    input  logic [NUM_REGS*32-1:0]    status_i,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    localparam int unsigned       IDX_W   = $clog2(NUM_REGS);
    localparam logic [31:0]       SPAN    = 32'(NUM_REGS * 4);
    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    apb_resp_state_e state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [31:0]       prdata_q;
    logic [32:0]       diff;
    logic [31:0]       off;
    logic [IDX_W-1:0]  idx;
    apb_err_cause_e    err_cause;
    logic              xfer_start;
    logic              load_rd;
    logic              wr_commit;
    logic [31:0]       rd_word;

    // Extra top bit keeps the borrow so addresses below BASE_ADDR are caught explicitly.
    assign diff = {1'b0, paddr_i} - {1'b0, BASE_ADDR};
    assign off  = diff[31:0];
    assign idx  = off[IDX_W+1:2];

    always_comb begin
        err_cause = ERR_NONE;
        if (paddr_i[1:0] != 2'b00) begin
            err_cause = ERR_ALIGN;
        end else if (diff[32] || (off >= SPAN)) begin
            err_cause = ERR_RANGE;
        end else if (pwrite_i && RO_MASK[idx]) begin
            err_cause = ERR_RO;
        end
    end

    assign xfer_start = psel_i && penable_i;
    assign pready_o   = (state_q == ST_ACCESS) && (cnt_q == '0) && psel_i;
    assign pslverr_o  = pready_o && (err_cause != ERR_NONE);
    assign wr_commit  = pready_o && pwrite_i && (err_cause == ERR_NONE);
    assign prdata_o   = prdata_q;

    // Read data is captured on the edge entering the pready cycle so it is registered when pready rises.
    assign load_rd = ((state_q == ST_IDLE) && xfer_start && (WAIT_LD == '0)) ||
                     ((state_q == ST_ACCESS) && psel_i && (cnt_q == WAIT_W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (xfer_start) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= WAIT_LD;
                    end
                end
                ST_ACCESS: begin
                    if (!psel_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!xfer_start) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (load_rd) begin
                prdata_q <= (!pwrite_i && (err_cause == ERR_NONE)) ? rd_word : 32'd0;
            end
        end
    end

    sne_apb_regbank #(
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK),
        .PULSE_MASK (PULSE_MASK)
    ) u_regbank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_vld     (wr_commit),
        .wr_idx     (idx),
        .wr_dat     (pwdata_i),
        .rd_idx     (idx),
        .rd_dat     (rd_word),
        .status_i   (status_i),
        .cfg_o      (cfg_o),
        .wr_pulse_o (wr_pulse_o)
    );

endmodule
